uart_rx_8n1: RTL and testbench

//   UART receiver, 8 data bits, no parity, 1 stop bit, LSB first. Counterpart
//   of the 8N1 transmitter. Samples the asynchronous RX pin on the system clock
//   and delivers bytes through a one-entry valid/ready output register.

---
 rtl/uart_rx_8n1.sv | 175 +++++++++++++++++
 tb/tb_uart_rx_8n1.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_8n1.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : uart_rx_8n1
//  Description : UART receiver, 8 data bits, no parity, 1 stop bit, LSB first.
//                Samples the asynchronous RX line through a 2-flop
//                synchroniser and hands bytes to the consumer through a
//                one-entry valid/ready output register.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx_8n1 #(
    parameter int CLK_FREQ = 25000000,
    parameter int BAUDRATE = 9600
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       rx_i,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUDRATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);

    localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BRK   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             rx_meta_q, rx_s_q;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
    logic             deliver;
    logic             stop_low;

    // Two-flop synchroniser; resets to the idle-high line level
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Frame FSM, bit timer, bit index, shift register and output register state
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shreg_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shreg_q     <= shreg_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    // Next-state logic: timer restarts on every state entry and every data sample
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        deliver   = 1'b0;
        stop_low  = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == CNT_HALF_LAST) begin
                    cnt_d = '0;
                    if (!rx_s_q) begin
                        state_d   = S_DATA;
                        bit_idx_d = '0;
                    end else begin
                        // Start bit gone by mid-bit: treat as a glitch
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_BIT_LAST) begin
                    cnt_d     = '0;
                    shreg_d   = {rx_s_q, shreg_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (cnt_q == CNT_BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        deliver = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        stop_low = 1'b1;
                        state_d  = S_BRK;
                    end
                end
            end
            S_BRK: begin
                // Hold off until the line returns high so a break cannot re-trigger
                cnt_d = '0;
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Output register: load on delivery if free or being drained, else flag overrun
    always_comb begin
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        frame_err_d = stop_low;
        overrun_d   = 1'b0;
        if (deliver) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = shreg_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_8n1.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_8n1
//  Description : Self-checking bench for uart_rx_8n1 at 10 clocks per bit.
//                A frame-level model predicts the output register contents
//                from the send times of whole frames.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_rx_8n1;

    localparam int C    = 10;   // clocks per bit
    localparam int LAT  = 98;   // edges from start-bit drive to valid rising
    localparam int MAXE = 8191;

    logic       clk = 1'b0;
    logic       rst_n_i = 1'b0;
    logic       rx_i = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, overrun, busy;

    uart_rx_8n1 #(.CLK_FREQ(1000000), .BAUDRATE(100000)) dut (
        .clk_i(clk), .rst_n_i(rst_n_i), .rx_i(rx_i),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .frame_err(frame_err), .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    // Frame completion events, indexed by the clock edge they take effect on
    bit         ev_on [0:MAXE];
    bit         ev_fe [0:MAXE];
    logic [7:0] ev_b  [0:MAXE];

    logic       m_valid = 1'b0;
    logic [7:0] m_data = 8'h00;
    logic       m_fe = 1'b0;
    logic       m_ovr = 1'b0;

    int  n_vec = 0;
    int  n_err = 0;
    bit  chk_on = 1'b0;
    int  fe_cnt = 0, ovr_cnt = 0, vld_rise = 0;
    logic prev_v = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            if (n_err < 40)
                $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Behavioural model of the output register at frame granularity
    always @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            m_valid <= 1'b0; m_data <= 8'h00; m_fe <= 1'b0; m_ovr <= 1'b0;
        end else begin
            int e;
            e = edge_n + 1;
            m_fe  <= 1'b0;
            m_ovr <= 1'b0;
            if (e <= MAXE && ev_on[e] && ev_fe[e]) begin
                m_fe <= 1'b1;
                if (m_valid && rx_ready) m_valid <= 1'b0;
            end else if (e <= MAXE && ev_on[e]) begin
                if (!m_valid || rx_ready) begin
                    m_data  <= ev_b[e];
                    m_valid <= 1'b1;
                end else begin
                    m_ovr <= 1'b1;
                end
            end else if (m_valid && rx_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    // Per-cycle compare against the model, plus event counters for literal checks
    always @(negedge clk) begin
        if (chk_on) begin
            check("outputs{valid,data,ferr,ovr}",
                  {21'd0, rx_valid, rx_data, frame_err, overrun},
                  {21'd0, m_valid, m_data, m_fe, m_ovr});
            fe_cnt  = fe_cnt + int'(frame_err);
            ovr_cnt = ovr_cnt + int'(overrun);
            if (rx_valid && !prev_v) vld_rise++;
            prev_v = rx_valid;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Drive one frame; hold_low extends a low stop bit to emulate a break
    task automatic send(input logic [7:0] b, input bit stop, input int hold_low);
        int n0;
        n0 = edge_n;
        rx_i = 1'b0;
        if (n0 + LAT <= MAXE) begin
            ev_on[n0 + LAT] = 1'b1;
            ev_fe[n0 + LAT] = !stop;
            ev_b [n0 + LAT] = b;
        end
        tick(C);
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            tick(C);
        end
        rx_i = stop;
        tick(C);
        if (!stop) tick(hold_low);
        rx_i = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat, n1, fe0, v0, o0;
        logic [7:0] d1;
        logic vnext;
        bit saw;

        tick(3);
        check("reset_valid", rx_valid, 0);
        check("reset_data", rx_data, 0);
        check("reset_ferr", frame_err, 0);
        check("reset_ovr", overrun, 0);
        check("reset_busy", busy, 0);
        rst_n_i = 1'b1;
        chk_on  = 1'b1;
        tick(5);

        // 1: single byte, consumer always ready
        rx_ready = 1'b1;
        lat = -1; d1 = 8'h00; vnext = 1'b1; n1 = edge_n;
        fork
            send(8'h55, 1'b1, 0);
            begin
                for (int k = 0; k < 150; k++) begin
                    @(negedge clk);
                    if (rx_valid) begin
                        lat = edge_n - n1;
                        d1  = rx_data;
                        break;
                    end
                end
                if (lat >= 0) begin
                    @(negedge clk);
                    vnext = rx_valid;
                end
            end
        join
        check("t1_latency_97to99", (lat >= 97 && lat <= 99), 1);
        check("t1_data", d1, 8'h55);
        check("t1_pulse_width", vnext, 0);
        check("t1_no_ferr", fe_cnt, 0);
        check("t1_no_ovr", ovr_cnt, 0);
        tick(20);

        // 2: short glitch on the line
        fe0 = fe_cnt; v0 = vld_rise;
        rx_i = 1'b0;
        tick(3);
        rx_i = 1'b1;
        saw = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (busy) saw = 1'b1;
        end
        tick(5);
        check("t2_busy_seen", saw, 1);
        check("t2_busy_back_idle", busy, 0);
        check("t2_no_valid", vld_rise - v0, 0);
        check("t2_no_ferr", fe_cnt - fe0, 0);

        // 3: framing error with break, then a good frame
        fe0 = fe_cnt; v0 = vld_rise;
        send(8'hA5, 1'b0, 20);
        tick(10);
        check("t3_busy_after_break", busy, 0);
        send(8'h3C, 1'b1, 0);
        tick(10);
        check("t3_ferr_pulses", fe_cnt - fe0, 1);
        check("t3_valid_pulses", vld_rise - v0, 1);
        check("t3_data", rx_data, 8'h3C);

        // 4: consumer stalled, second byte overruns
        rx_ready = 1'b0;
        o0 = ovr_cnt;
        send(8'h11, 1'b1, 0);
        send(8'h22, 1'b1, 0);
        tick(5);
        check("t4_held_valid", rx_valid, 1);
        check("t4_held_data", rx_data, 8'h11);
        check("t4_ovr_pulses", ovr_cnt - o0, 1);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        check("t4_valid_after_accept", rx_valid, 0);
        check("t4_data_after_accept", rx_data, 8'h11);
        tick(5);

        // 5: reset during bit 4 of 0x0F, then back-to-back frames
        rx_ready = 1'b1;
        rx_i = 1'b0;
        tick(C);
        for (int i = 0; i < 4; i++) begin
            rx_i = (8'h0F >> i) & 8'h01;
            tick(C);
        end
        rx_i = 1'b1;  // bit 4 of 0x0F is 0, but release happens with line high
        rx_i = 1'b0;
        tick(5);
        rst_n_i = 1'b0;
        for (int e = 0; e <= MAXE; e++) ev_on[e] = 1'b0;
        rx_i = 1'b1;
        #2;
        check("t5_reset_busy", busy, 0);
        check("t5_reset_valid", rx_valid, 0);
        tick(3);
        rst_n_i = 1'b1;
        tick(5);
        v0 = vld_rise;
        send(8'hFF, 1'b1, 0);
        send(8'h00, 1'b1, 0);
        tick(10);
        check("t5_valid_pulses", vld_rise - v0, 2);
        check("t5_last_data", rx_data, 8'h00);

        // 6: new byte completes in the same cycle the held byte is accepted
        rx_ready = 1'b0;
        send(8'h42, 1'b1, 0);
        tick(5);
        check("t6_first_held", rx_data, 8'h42);
        o0 = ovr_cnt;
        fork
            send(8'h80, 1'b1, 0);
            begin
                repeat (LAT - 1) @(posedge clk);
                #1 rx_ready = 1'b1;
                @(posedge clk);
                #1 rx_ready = 1'b0;
            end
        join
        tick(3);
        check("t6_data", rx_data, 8'h80);
        check("t6_valid", rx_valid, 1);
        check("t6_no_ovr", ovr_cnt - o0, 0);

        tick(5);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
